ram_1r1w_arbiter: RTL and testbench

Round-robin access scheduler that shares one banked `ram_1R1W` instance between `NRD` read clients and `NWR` write clients. Each cycle it grants at most one read and one write, drives the RAM's single read port and single write port, and returns read data tagged by a one-hot valid after the RAM read latency. It resolves same-address read/write collisions deterministically with read-after-write ordering and bounded stall. It sits between the replicated-read client logic and the memory array.

---
 rtl/ram_1r1w_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_1r1w_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_arbiter.sv
// rtl/ram_1r1w_arbiter.sv - round-robin read/write scheduler in front of a shared 1R1W RAM
module ram_1r1w_arbiter #(
    parameter int NRD     = 4,
    parameter int NWR     = 2,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        rd_req,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_gnt,
    output logic [NRD-1:0]        rd_vld,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [NWR-1:0]        wr_req,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_din,
    output logic [NWR-1:0]        wr_gnt,
    output logic [ADDR_W-1:0]     r_addr,
    input  logic [DATA_W-1:0]     r_dout,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [DATA_W-1:0]     w_din,
    output logic                  w_enb
);

    localparam int RPW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int WPW = (NWR > 1) ? $clog2(NWR) : 1;

    logic [RPW-1:0]    rd_ptr;
    logic [WPW-1:0]    wr_ptr;
    logic              stall_q;

    logic              rd_found;
    logic [RPW-1:0]    rd_cand;
    logic              wr_found;
    logic [WPW-1:0]    wr_cand;
    logic [ADDR_W-1:0] rd_cand_addr;
    logic [ADDR_W-1:0] wr_cand_addr;
    logic [DATA_W-1:0] wr_cand_din;
    logic              collision;
    logic              rd_take;
    logic              wr_take;

    logic [NRD-1:0]    vld_pipe [LATENCY];

    // Client index reached by stepping off slots upward from base, wrapping at n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

    // Read candidate: first requester at or above rd_ptr, with wrap-around.
    always_comb begin
        rd_found = 1'b0;
        rd_cand  = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rd_found && rd_req[wrap_idx(int'(rd_ptr), i, NRD)]) begin
                rd_found = 1'b1;
                rd_cand  = RPW'(wrap_idx(int'(rd_ptr), i, NRD));
            end
        end
    end

    // Write candidate: same rotating search over the write clients.
    always_comb begin
        wr_found = 1'b0;
        wr_cand  = '0;
        for (int i = 0; i < NWR; i++) begin
            if (!wr_found && wr_req[wrap_idx(int'(wr_ptr), i, NWR)]) begin
                wr_found = 1'b1;
                wr_cand  = WPW'(wrap_idx(int'(wr_ptr), i, NWR));
            end
        end
    end

    // Collision arbitration: the write goes first, the read follows one cycle later
    // so it sees the new data and is never held off for more than one cycle.
    always_comb begin
        rd_cand_addr = rd_addr[rd_cand*ADDR_W +: ADDR_W];
        wr_cand_addr = wr_addr[wr_cand*ADDR_W +: ADDR_W];
        wr_cand_din  = wr_din[wr_cand*DATA_W +: DATA_W];
        collision    = rd_found && wr_found && (rd_cand_addr == wr_cand_addr);
        rd_take      = rd_found && (!collision || stall_q);
        wr_take      = wr_found && (!collision || !stall_q);
    end

    // Grants and RAM port drive; everything idles to zero when nothing is granted.
    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        r_addr = '0;
        w_addr = '0;
        w_din  = '0;
        if (rd_take) begin
            rd_gnt = NRD'(1) << rd_cand;
            r_addr = rd_cand_addr;
        end
        if (wr_take) begin
            wr_gnt = NWR'(1) << wr_cand;
            w_addr = wr_cand_addr;
            w_din  = wr_cand_din;
        end
        w_enb = wr_take;
    end

    // Round-robin pointers advance past the granted client; stall flag arms on a fresh collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (rd_take) begin
                rd_ptr <= (rd_cand == RPW'(NRD - 1)) ? '0 : rd_cand + RPW'(1);
            end
            if (wr_take) begin
                wr_ptr <= (wr_cand == WPW'(NWR - 1)) ? '0 : wr_cand + WPW'(1);
            end
            stall_q <= collision && !stall_q;
        end
    end

    // Read-grant one-hot delayed by the RAM latency; reset drops responses in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_gnt;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign rd_vld  = vld_pipe[LATENCY-1];
    assign rd_data = r_dout;

endmodule

// File: tb/tb_ram_1r1w_arbiter.sv
// tb/tb_ram_1r1w_arbiter.sv - self-checking bench for ram_1r1w_arbiter
module tb_ram_1r1w_arbiter;

    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic              clk;
    logic              rst;
    logic [NRD-1:0]    rd_req;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_gnt;
    logic [NRD-1:0]    rd_vld;
    logic [DW-1:0]     rd_data;
    logic [NWR-1:0]    wr_req;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_din;
    logic [NWR-1:0]    wr_gnt;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_dout;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic              w_enb;

    int n_cmp = 0;
    int n_err = 0;

    ram_1r1w_arbiter #(.NRD(NRD), .NWR(NWR), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_gnt(wr_gnt),
        .r_addr(r_addr), .r_dout(r_dout), .w_addr(w_addr), .w_din(w_din), .w_enb(w_enb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 1R1W RAM with LAT-cycle read latency
    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [LAT];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    end

    always @(posedge clk) begin
        if (w_enb) mem[w_addr] <= w_din;
        rpipe[0] <= mem[r_addr];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign r_dout = rpipe[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req  = '0;
        wr_req  = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_din  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (rd_vld !== 4'b0)  begin n_err++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
        n_cmp++; if (rd_gnt !== 4'b0)  begin n_err++; $display("FAIL reset_rd_gnt got=%b exp=0", rd_gnt); end
        n_cmp++; if (wr_gnt !== 2'b0)  begin n_err++; $display("FAIL reset_wr_gnt got=%b exp=0", wr_gnt); end
        n_cmp++; if (w_enb !== 1'b0)   begin n_err++; $display("FAIL reset_w_enb got=%b exp=0", w_enb); end
        n_cmp++; if (r_addr !== 11'h0) begin n_err++; $display("FAIL reset_r_addr got=%h exp=0", r_addr); end
        n_cmp++; if (w_addr !== 11'h0) begin n_err++; $display("FAIL reset_w_addr got=%h exp=0", w_addr); end
        n_cmp++; if (w_din !== 32'h0)  begin n_err++; $display("FAIL reset_w_din got=%h exp=0", w_din); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_read_fairness();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        rd_req  = 4'hF;
        rd_addr = {11'h013, 11'h012, 11'h011, 11'h010};
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (rd_gnt !== exp_g[c]) begin n_err++; $display("FAIL fair_rd_gnt[%0d] got=%b exp=%b", c, rd_gnt, exp_g[c]); end
            if (c >= LAT) begin
                n_cmp++; if (rd_vld !== exp_g[c-LAT]) begin n_err++; $display("FAIL fair_rd_vld[%0d] got=%b exp=%b", c, rd_vld, exp_g[c-LAT]); end
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_read_after_write();
        wr_req = 2'b01;
        wr_addr[0 +: AW] = 11'h155;
        wr_din[0 +: DW]  = 32'hDEADBEEF;
        #1;
        n_cmp++; if (wr_gnt !== 2'b01) begin n_err++; $display("FAIL raw_wr_gnt got=%b exp=01", wr_gnt); end
        n_cmp++; if (w_enb !== 1'b1 || w_addr !== 11'h155 || w_din !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL raw_wport got=%b/%h/%h exp=1/155/deadbeef", w_enb, w_addr, w_din); end
        step();
        idle_inputs();
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = 11'h155;
        #1;
        n_cmp++; if (rd_gnt !== 4'b0100) begin n_err++; $display("FAIL raw_rd_gnt got=%b exp=0100", rd_gnt); end
        n_cmp++; if (r_addr !== 11'h155) begin n_err++; $display("FAIL raw_r_addr got=%h exp=155", r_addr); end
        step();
        idle_inputs();
        repeat (LAT - 1) step();
        #1;
        n_cmp++; if (rd_vld !== 4'b0100) begin n_err++; $display("FAIL raw_rd_vld got=%b exp=0100", rd_vld); end
        n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_rd_data got=%h exp=deadbeef", rd_data); end
        step();
    endtask

    task automatic test_single_collision();
        idle_inputs();
        wr_req = 2'b01;
        wr_addr[0 +: AW] = 11'h2A0;
        wr_din[0 +: DW]  = 32'h1;
        step();
        idle_inputs();
        step();
        rd_req = 4'b0010;
        rd_addr[1*AW +: AW] = 11'h2A0;
        wr_req = 2'b01;
        wr_addr[0 +: AW] = 11'h2A0;
        wr_din[0 +: DW]  = 32'h2;
        #1;
        n_cmp++; if (wr_gnt !== 2'b01) begin n_err++; $display("FAIL col_c0_wr_gnt got=%b exp=01", wr_gnt); end
        n_cmp++; if (rd_gnt !== 4'b0)  begin n_err++; $display("FAIL col_c0_rd_gnt got=%b exp=0000", rd_gnt); end
        step();
        wr_req = 2'b00;
        #1;
        n_cmp++; if (rd_gnt !== 4'b0010) begin n_err++; $display("FAIL col_c1_rd_gnt got=%b exp=0010", rd_gnt); end
        step();
        idle_inputs();
        repeat (LAT - 1) step();
        #1;
        n_cmp++; if (rd_vld !== 4'b0010) begin n_err++; $display("FAIL col_rd_vld got=%b exp=0010", rd_vld); end
        n_cmp++; if (rd_data !== 32'h2) begin n_err++; $display("FAIL col_rd_data got=%h exp=2", rd_data); end
        step();
    endtask

    task automatic test_persistent_collision();
        logic [DW-1:0] expd [int];
        idle_inputs();
        step();
        rd_req = 4'b0001;
        rd_addr[0 +: AW] = 11'h010;
        wr_req = 2'b01;
        wr_addr[0 +: AW] = 11'h010;
        for (int i = 0; i < 8; i++) begin
            wr_din[0 +: DW] = 32'h100 + i;
            #1;
            if (i % 2 == 0) begin
                n_cmp++; if (wr_gnt !== 2'b01 || rd_gnt !== 4'b0)
                    begin n_err++; $display("FAIL pers_write_turn[%0d] got wr=%b rd=%b exp wr=01 rd=0000", i, wr_gnt, rd_gnt); end
            end else begin
                n_cmp++; if (rd_gnt !== 4'b0001 || wr_gnt !== 2'b0)
                    begin n_err++; $display("FAIL pers_read_turn[%0d] got rd=%b wr=%b exp rd=0001 wr=00", i, rd_gnt, wr_gnt); end
                expd[i + LAT] = 32'h100 + i - 1;
            end
            if (expd.exists(i)) begin
                n_cmp++; if (rd_vld !== 4'b0001 || rd_data !== expd[i])
                    begin n_err++; $display("FAIL pers_resp[%0d] got vld=%b data=%h exp vld=0001 data=%h", i, rd_vld, rd_data, expd[i]); end
            end
            step();
        end
        idle_inputs();
        for (int i = 8; i < 8 + LAT; i++) begin
            #1;
            if (expd.exists(i)) begin
                n_cmp++; if (rd_vld !== 4'b0001 || rd_data !== expd[i])
                    begin n_err++; $display("FAIL pers_resp[%0d] got vld=%b data=%h exp vld=0001 data=%h", i, rd_vld, rd_data, expd[i]); end
            end
            step();
        end
    endtask

    task automatic test_reset_in_flight();
        idle_inputs();
        rd_req = 4'b0010;
        rd_addr[1*AW +: AW] = 11'h030;
        wr_req = 2'b01;
        wr_addr[0 +: AW] = 11'h031;
        wr_din[0 +: DW]  = 32'h55;
        #1;
        n_cmp++; if (rd_gnt !== 4'b0010 || wr_gnt !== 2'b01)
            begin n_err++; $display("FAIL rif_setup got rd=%b wr=%b exp rd=0010 wr=01", rd_gnt, wr_gnt); end
        step();
        idle_inputs();
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = 11'h032;
        #1;
        n_cmp++; if (rd_gnt !== 4'b0100) begin n_err++; $display("FAIL rif_grant got=%b exp=0100", rd_gnt); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (rd_vld !== 4'b0) begin n_err++; $display("FAIL rif_vld_at_reset got=%b exp=0", rd_vld); end
        idle_inputs();
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            #2;
            n_cmp++; if (rd_vld !== 4'b0) begin n_err++; $display("FAIL rif_vld_held[%0d] got=%b exp=0", i, rd_vld); end
        end
        rst = 1'b1;
        #1;
        rd_req  = 4'hF;
        rd_addr = {11'h043, 11'h042, 11'h041, 11'h040};
        wr_req  = 2'b11;
        wr_addr = {11'h051, 11'h050};
        #1;
        n_cmp++; if (rd_gnt !== 4'b0001) begin n_err++; $display("FAIL rif_first_rd_gnt got=%b exp=0001", rd_gnt); end
        n_cmp++; if (wr_gnt !== 2'b01)   begin n_err++; $display("FAIL rif_first_wr_gnt got=%b exp=01", wr_gnt); end
        n_cmp++; if (rd_vld !== 4'b0)    begin n_err++; $display("FAIL rif_vld_after got=%b exp=0", rd_vld); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_write_fairness();
        logic [1:0] reqs  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
        apply_reset();
        wr_addr = {11'h061, 11'h060};
        wr_din  = {32'hA1, 32'hA0};
        for (int c = 0; c < 4; c++) begin
            wr_req = reqs[c];
            #1;
            n_cmp++; if (wr_gnt !== exp_g[c]) begin n_err++; $display("FAIL wfair_gnt[%0d] got=%b exp=%b", c, wr_gnt, exp_g[c]); end
            n_cmp++; if (w_enb !== (exp_g[c] != 2'b00)) begin n_err++; $display("FAIL wfair_w_enb[%0d] got=%b exp=%b", c, w_enb, exp_g[c] != 2'b00); end
            if (reqs[c] == 2'b00) begin
                n_cmp++; if (w_addr !== 11'h0 || w_din !== 32'h0)
                    begin n_err++; $display("FAIL wfair_idle_wport got=%h/%h exp=0/0", w_addr, w_din); end
            end
            step();
        end
        idle_inputs();
    endtask

    // Randomized traffic over a small address window against a reference model
    task automatic test_random();
        int            mrp, mwp, cyc, rc, wc;
        bit            mst, col, rg, wg;
        logic [DW-1:0] mm       [int];
        logic [3:0]    pend_vld [int];
        logic [DW-1:0] pend_dat [int];
        logic [3:0]    exp_rg, exp_vld;
        logic [1:0]    exp_wg;
        logic [AW-1:0] ra, wa, exp_ra, exp_wa;
        logic [DW-1:0] wd, exp_wd, rdat;
        apply_reset();
        mrp = 0; mwp = 0; mst = 1'b0; cyc = 0;
        for (int n = 0; n < 400; n++) begin
            rd_req = 4'($urandom);
            wr_req = 2'($urandom);
            for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = 11'h700 + 11'($urandom_range(0, 3));
            for (int i = 0; i < NWR; i++) begin
                wr_addr[i*AW +: AW] = 11'h700 + 11'($urandom_range(0, 3));
                wr_din[i*DW +: DW]  = $urandom;
            end
            #1;
            rc = -1;
            for (int j = 0; j < NRD; j++) if (rc < 0 && rd_req[(mrp + j) % NRD]) rc = (mrp + j) % NRD;
            wc = -1;
            for (int j = 0; j < NWR; j++) if (wc < 0 && wr_req[(mwp + j) % NWR]) wc = (mwp + j) % NWR;
            ra  = (rc >= 0) ? rd_addr[rc*AW +: AW] : 11'h0;
            wa  = (wc >= 0) ? wr_addr[wc*AW +: AW] : 11'h0;
            wd  = (wc >= 0) ? wr_din[wc*DW +: DW] : 32'h0;
            col = (rc >= 0) && (wc >= 0) && (ra == wa);
            rg  = (rc >= 0) && (!col || mst);
            wg  = (wc >= 0) && (!col || !mst);
            exp_rg  = rg ? 4'(1 << rc) : 4'b0;
            exp_wg  = wg ? 2'(1 << wc) : 2'b0;
            exp_ra  = rg ? ra : 11'h0;
            exp_wa  = wg ? wa : 11'h0;
            exp_wd  = wg ? wd : 32'h0;
            exp_vld = pend_vld.exists(cyc) ? pend_vld[cyc] : 4'b0;
            n_cmp++; if (rd_gnt !== exp_rg) begin n_err++; $display("FAIL rnd_rd_gnt[%0d] got=%b exp=%b", cyc, rd_gnt, exp_rg); end
            n_cmp++; if (wr_gnt !== exp_wg) begin n_err++; $display("FAIL rnd_wr_gnt[%0d] got=%b exp=%b", cyc, wr_gnt, exp_wg); end
            n_cmp++; if (r_addr !== exp_ra) begin n_err++; $display("FAIL rnd_r_addr[%0d] got=%h exp=%h", cyc, r_addr, exp_ra); end
            n_cmp++; if (w_enb !== wg || w_addr !== exp_wa || w_din !== exp_wd)
                begin n_err++; $display("FAIL rnd_wport[%0d] got=%b/%h/%h exp=%b/%h/%h", cyc, w_enb, w_addr, w_din, wg, exp_wa, exp_wd); end
            n_cmp++; if (rd_vld !== exp_vld) begin n_err++; $display("FAIL rnd_rd_vld[%0d] got=%b exp=%b", cyc, rd_vld, exp_vld); end
            if (exp_vld != 4'b0) begin
                n_cmp++; if (rd_data !== pend_dat[cyc]) begin n_err++; $display("FAIL rnd_rd_data[%0d] got=%h exp=%h", cyc, rd_data, pend_dat[cyc]); end
            end
            if (rg) begin
                rdat = mm.exists(int'(ra)) ? mm[int'(ra)] : 32'h0;
                pend_vld[cyc + LAT] = exp_rg;
                pend_dat[cyc + LAT] = rdat;
                mrp = (rc + 1) % NRD;
            end
            if (wg) begin
                mm[int'(wa)] = wd;
                mwp = (wc + 1) % NWR;
            end
            mst = col && !mst;
            cyc++;
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_read_fairness();
        test_read_after_write();
        test_single_collision();
        test_persistent_collision();
        test_reset_in_flight();
        test_write_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
